// File: rtl/dram_pkg.sv
// Shared state encodings and read-pipeline depth for the DRAM responder.
// Pure definitions; no logic, no latency, no backpressure.
package dram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int RD_LAT = 2;

endpackage

// File: rtl/dram_wbuf.sv
// Write buffer FIFO of {addr, data} plus combinational youngest-match lookup; zero-latency lookup.
// Push is ignored when full unless a pop happens the same cycle; pop is ignored when empty.
module dram_wbuf
    import dram_pkg::*;
#(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 32,
    parameter int WB_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  push,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic [DATA_WIDTH-1:0] push_dat,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] lk_addr,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH-1:0] head_addr,
    output logic [DATA_WIDTH-1:0] head_dat,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] hit_dat
);

    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] ent_addr_q [WB_DEPTH];
    logic [DATA_WIDTH-1:0] ent_dat_q  [WB_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  push_ok, pop_ok;

    assign full      = (cnt_q == CW'(WB_DEPTH));
    assign empty     = (cnt_q == '0);
    assign head_addr = ent_addr_q[rd_ptr_q];
    assign head_dat  = ent_dat_q[rd_ptr_q];
    assign pop_ok    = pop && !empty;
    assign push_ok   = push && (!full || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push_ok && !pop_ok)      cnt_d = cnt_q + CW'(1);
        else if (pop_ok && !push_ok) cnt_d = cnt_q - CW'(1);
    end

    // Walk oldest to youngest so the last (youngest) match wins.
    always_comb begin
        hit     = 1'b0;
        hit_dat = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if ((CW'(i) < cnt_q) && (ent_addr_q[rd_ptr_q + PW'(i)] == lk_addr)) begin
                hit     = 1'b1;
                hit_dat = ent_dat_q[rd_ptr_q + PW'(i)];
            end
        end
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            ent_addr_q[wr_ptr_q] <= push_addr;
            ent_dat_q[wr_ptr_q]  <= push_dat;
        end
    end

endmodule

// File: rtl/dram_resp.sv
// DRAM responder on one single-port SRAM: reads return after RD_LAT=2 edges, writes are buffered; optional zero sweep under DRAM_RESP_INIT_CLEAR_EN.
// rdy_data is low until init finishes; a write into a full buffer alongside a read is dropped and flagged on wb_ovf.
module dram_resp
    import dram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int WB_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  dram_en_rd,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic                  dram_en_wr,
    input  logic [ADDR_WIDTH-1:0] addr_out,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic                  dram_valid,
    output logic                  rdy_data,
    output logic                  wb_ovf,
    output logic                  mem_cen,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_d,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    state_t                  state_q, state_d;
    logic                    mem_cen_q, mem_cen_d;
    logic                    mem_wen_q, mem_wen_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_d_q, mem_d_d;
    logic                    wb_ovf_q, wb_ovf_d;
    logic [RD_LAT-1:0]       pv_q, pv_d;
    logic [RD_LAT-1:0]       ph_q, ph_d;
    logic [RD_LAT-1:0][DATA_WIDTH-1:0] pd_q, pd_d;
    logic [DATA_WIDTH-1:0]   data_in_q, data_in_d;
    logic                    dram_valid_q, dram_valid_d;
`ifdef DRAM_RESP_INIT_CLEAR_EN
    logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
`endif

    logic                    rd_go, wr_go;
    logic                    wb_push, wb_pop, wb_full, wb_empty, wb_hit;
    logic [ADDR_WIDTH-1:0]   wb_head_addr;
    logic [DATA_WIDTH-1:0]   wb_head_dat, wb_hit_dat;

    assign rdy_data   = (state_q == ST_RUN);
    assign rd_go      = rdy_data && dram_en_rd;
    assign wr_go      = rdy_data && dram_en_wr;
    assign data_in    = data_in_q;
    assign dram_valid = dram_valid_q;
    assign wb_ovf     = wb_ovf_q;
    assign mem_cen    = mem_cen_q;
    assign mem_wen    = mem_wen_q;
    assign mem_addr   = mem_addr_q;
    assign mem_d      = mem_d_q;

    dram_wbuf #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .WB_DEPTH   (WB_DEPTH)
    ) u_wbuf (
        .clk       (clk),
        .srstn     (srstn),
        .push      (wb_push),
        .push_addr (addr_out),
        .push_dat  (data_out),
        .pop       (wb_pop),
        .lk_addr   (addr_in),
        .full      (wb_full),
        .empty     (wb_empty),
        .head_addr (wb_head_addr),
        .head_dat  (wb_head_dat),
        .hit       (wb_hit),
        .hit_dat   (wb_hit_dat)
    );

    always_comb begin
        state_d    = state_q;
        mem_cen_d  = 1'b0;
        mem_wen_d  = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_d_d    = mem_d_q;
        wb_ovf_d   = wb_ovf_q;
        wb_push    = 1'b0;
        wb_pop     = 1'b0;
`ifdef DRAM_RESP_INIT_CLEAR_EN
        init_cnt_d = init_cnt_q;
`endif
        case (state_q)
            ST_INIT: begin
`ifdef DRAM_RESP_INIT_CLEAR_EN
                mem_cen_d  = 1'b1;
                mem_wen_d  = 1'b1;
                mem_addr_d = init_cnt_q;
                mem_d_d    = '0;
                init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
                if (&init_cnt_q) state_d = ST_RUN;
`else
                state_d = ST_RUN;
`endif
            end
            ST_RUN: begin
                // The read owns the port; a same-cycle write must wait in the buffer.
                if (rd_go) begin
                    mem_cen_d  = 1'b1;
                    mem_addr_d = addr_in;
                    if (wr_go) begin
                        if (wb_full) wb_ovf_d = 1'b1;
                        else         wb_push  = 1'b1;
                    end
                end else if (!wb_empty) begin
                    mem_cen_d  = 1'b1;
                    mem_wen_d  = 1'b1;
                    mem_addr_d = wb_head_addr;
                    mem_d_d    = wb_head_dat;
                    wb_pop     = 1'b1;
                    wb_push    = wr_go;
                end else if (wr_go) begin
                    mem_cen_d  = 1'b1;
                    mem_wen_d  = 1'b1;
                    mem_addr_d = addr_out;
                    mem_d_d    = data_out;
                end
            end
        endcase
    end

    // Forwarding decision is captured at request time and rides alongside the SRAM access.
    always_comb begin
        pv_d         = {pv_q[RD_LAT-2:0], rd_go};
        ph_d         = {ph_q[RD_LAT-2:0], rd_go && wb_hit};
        pd_d         = {pd_q[RD_LAT-2:0], wb_hit_dat};
        dram_valid_d = pv_q[RD_LAT-1];
        data_in_d    = data_in_q;
        if (pv_q[RD_LAT-1]) begin
            data_in_d = ph_q[RD_LAT-1] ? pd_q[RD_LAT-1] : mem_q;
        end
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state_q      <= ST_INIT;
            mem_cen_q    <= 1'b0;
            mem_wen_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_d_q      <= '0;
            wb_ovf_q     <= 1'b0;
            pv_q         <= '0;
            ph_q         <= '0;
            pd_q         <= '0;
            data_in_q    <= '0;
            dram_valid_q <= 1'b0;
`ifdef DRAM_RESP_INIT_CLEAR_EN
            init_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            mem_cen_q    <= mem_cen_d;
            mem_wen_q    <= mem_wen_d;
            mem_addr_q   <= mem_addr_d;
            mem_d_q      <= mem_d_d;
            wb_ovf_q     <= wb_ovf_d;
            pv_q         <= pv_d;
            ph_q         <= ph_d;
            pd_q         <= pd_d;
            data_in_q    <= data_in_d;
            dram_valid_q <= dram_valid_d;
`ifdef DRAM_RESP_INIT_CLEAR_EN
            init_cnt_q   <= init_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_dram_resp.sv
// Scoreboard bench for dram_resp: stimulus pushes expected read data, a negedge monitor pops and compares.
module tb_dram_resp;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int WB = 4;
`ifdef DRAM_RESP_INIT_CLEAR_EN
    localparam int EXP_INIT = 1 << AW;
    localparam bit CLR      = 1'b1;
`else
    localparam int EXP_INIT = 1;
    localparam bit CLR      = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          srstn;
    logic          dram_en_rd, dram_en_wr;
    logic [AW-1:0] addr_in, addr_out;
    logic [DW-1:0] data_out, data_in;
    logic          dram_valid, rdy_data, wb_ovf, mem_cen, mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_d, mem_q;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int n_vld = 0;
    int n_rd  = 0;
    int n_fl  = 0;
    int rel   = 0;
    int m_cnt = 0;
    bit m_ovf = 1'b0;
    logic [DW-1:0] exp_q[$];
    int            due_q[$];
    logic [DW-1:0] sram    [logic [AW-1:0]];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    dram_resp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WB_DEPTH(WB)) u_dut (
        .clk(clk), .srstn(srstn),
        .dram_en_rd(dram_en_rd), .addr_in(addr_in),
        .dram_en_wr(dram_en_wr), .addr_out(addr_out), .data_out(data_out),
        .data_in(data_in), .dram_valid(dram_valid), .rdy_data(rdy_data), .wb_ovf(wb_ovf),
        .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_d(mem_d), .mem_q(mem_q)
    );

    always @(posedge clk) begin
        if (mem_cen) begin
            if (mem_wen) sram[mem_addr] = mem_d;
            else         mem_q <= sram.exists(mem_addr) ? sram[mem_addr] : '0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    always @(negedge clk) begin
        if (dram_valid) begin
            n_vld++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: dram_valid=1 at cycle %0d, expected no read outstanding", cyc);
            end else begin
                logic [DW-1:0] e;
                int            d;
                e = exp_q.pop_front();
                d = due_q.pop_front();
                check("rd_data", data_in, e);
                check("rd_latency", cyc, d);
            end
        end
    end

    // One request cycle: model predicts the read result, buffer occupancy and drops.
    task automatic io(input bit rd, input logic [AW-1:0] ra, input bit wr,
                      input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        dram_en_rd = rd;
        addr_in    = ra;
        dram_en_wr = wr;
        addr_out   = wa;
        data_out   = wd;
        if (rd) begin
            exp_q.push_back(ref_rd(ra));
            due_q.push_back(cyc + 3);
            n_rd++;
        end
        if (wr) begin
            if (rd && m_cnt == WB) begin
                m_ovf = 1'b1;
            end else begin
                ref_mem[wa] = wd;
                if (rd) m_cnt++;
            end
        end else if (!rd && m_cnt > 0) begin
            m_cnt--;
        end
        @(posedge clk);
        #1;
        dram_en_rd = 1'b0;
        dram_en_wr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) io(1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic do_reset(input int n);
        int w;
        srstn = 1'b0;
        exp_q.delete();
        due_q.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
        if (CLR) ref_mem.delete();
        repeat (n) @(posedge clk);
        #1;
        check("rst_data_in", data_in, 0);
        check("rst_dram_valid", dram_valid, 0);
        check("rst_rdy_data", rdy_data, 0);
        check("rst_wb_ovf", wb_ovf, 0);
        check("rst_mem_cen", mem_cen, 0);
        check("rst_mem_wen", mem_wen, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_d", mem_d, 0);
        srstn = 1'b1;
        rel   = cyc;
        w     = 0;
        while (!rdy_data && w < EXP_INIT + 10) begin
            @(negedge clk);
            w++;
        end
        check("rdy_rise_cycles", cyc - rel, EXP_INIT);
    endtask

`ifdef DRAM_RESP_INIT_CLEAR_EN
    logic          s_rd = 1'b0;
    logic [3:0]    s_ai = '0;
    logic [DW-1:0] s_di, s_md, s_q;
    logic          s_vld, s_rdy, s_ovf, s_cen, s_wen;
    logic [3:0]    s_ma;
    logic [DW-1:0] s_mem [16];
    int            s_rise = -1;

    dram_resp #(.DATA_WIDTH(DW), .ADDR_WIDTH(4), .WB_DEPTH(WB)) u_small (
        .clk(clk), .srstn(srstn),
        .dram_en_rd(s_rd), .addr_in(s_ai),
        .dram_en_wr(1'b0), .addr_out(4'h0), .data_out(32'h0),
        .data_in(s_di), .dram_valid(s_vld), .rdy_data(s_rdy), .wb_ovf(s_ovf),
        .mem_cen(s_cen), .mem_wen(s_wen), .mem_addr(s_ma), .mem_d(s_md), .mem_q(s_q)
    );

    always @(posedge clk) begin
        if (!srstn) begin
            for (int i = 0; i < 16; i++) s_mem[i] = 32'hDEAD_0000 | i;
        end else if (s_cen) begin
            if (s_wen) s_mem[s_ma] = s_md;
            else       s_q <= s_mem[s_ma];
        end
    end

    always @(negedge clk) begin
        if (!srstn)                  s_rise = -1;
        else if (s_rdy && s_rise < 0) s_rise = cyc;
    end
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        int            v0;
        logic [AW-1:0] a;
        srstn      = 1'b0;
        dram_en_rd = 1'b0;
        dram_en_wr = 1'b0;
        addr_in    = '0;
        addr_out   = '0;
        data_out   = '0;
        do_reset(3);

`ifdef DRAM_RESP_INIT_CLEAR_EN
        check("small_rdy_rise_cycles", s_rise - rel, 16);
        for (int k = 0; k < 16; k++) begin
            int w;
            s_ai = 4'(k);
            s_rd = 1'b1;
            @(posedge clk);
            #1;
            s_rd = 1'b0;
            w = 0;
            while (!s_vld && w < 5) begin
                @(negedge clk);
                w++;
            end
            check("small_cleared_read", s_vld ? s_di : 32'hFFFF_FFFF, 0);
            @(posedge clk);
            #1;
        end
`endif

        // Write, let it settle, read back from SRAM.
        io(1'b0, '0, 1'b1, 8'h10, 32'h5);
        idle(10);
        io(1'b1, 8'h10, 1'b0, '0, '0);
        idle(4);

        // Same-cycle read/write returns the old value; next read is forwarded.
        io(1'b0, '0, 1'b1, 8'h20, 32'h77);
        idle(3);
        io(1'b1, 8'h20, 1'b1, 8'h20, 32'hA);
        io(1'b1, 8'h20, 1'b0, '0, '0);
        idle(6);

        // Fill the buffer under continuous reads, then overflow it.
        check("ovf_initially_clear", wb_ovf, 0);
        io(1'b0, '0, 1'b1, 8'h04, 32'h44);
        idle(3);
        for (int k = 0; k < 4; k++) io(1'b1, 8'h50, 1'b1, AW'(k), 32'h100 + k);
        io(1'b1, 8'h50, 1'b1, 8'h04, 32'h99);
        check("wb_ovf_set", wb_ovf, m_ovf);
        idle(8);
        for (int k = 0; k < 5; k++) io(1'b1, AW'(k), 1'b0, '0, '0);
        idle(4);
        check("wb_ovf_sticky", wb_ovf, 1);

        // Mixed traffic: rd+wr, forwarded read, drain+enqueue, idle drain.
        for (int i = 0; i < 100; i++) begin
            a = 8'h30 + AW'((i / 4) % 8);
            case (i % 4)
                0:       io(1'b1, a, 1'b1, a, $urandom);
                1:       io(1'b1, a, 1'b0, '0, '0);
                2:       io(1'b0, '0, 1'b1, a + AW'(1), $urandom);
                default: idle(1);
            endcase
        end
        idle(8);

        // Reset with two reads in flight: neither may complete.
        io(1'b1, 8'h10, 1'b0, '0, '0);
        io(1'b1, 8'h20, 1'b0, '0, '0);
        v0   = n_vld;
        n_fl += 2;
        do_reset(3);
        idle(5);
        check("no_valid_after_reset", n_vld - v0, 0);

        io(1'b1, 8'h10, 1'b0, '0, '0);
        idle(5);

        check("valid_count", n_vld, n_rd - n_fl);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dram_resp.md
DRAM_RESP -- requirements
Module: dram_resp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 32, word width.
REQ-002 SHALL have parameter ADDR_WIDTH, 18, word address width; memory depth is 2**ADDR_WIDTH.
REQ-003 SHALL have parameter WB_DEPTH, 4, write-buffer entries (power of two, 2..8).
REQ-004 SHALL have ports, in this order:
- clk  in  1  sole clock.
- srstn  in  1  reset, asynchronous, active-low.
- dram_en_rd  in  1  read request.
- addr_in  in  ADDR_WIDTH  read address.
- dram_en_wr  in  1  write request.
- addr_out  in  ADDR_WIDTH  write address.
- data_out  in  DATA_WIDTH  write data.
- data_in  out  DATA_WIDTH  read data.
- dram_valid  out  1  data_in valid strobe.
- rdy_data  out  1  responder ready for requests.
- wb_ovf  out  1  sticky write-drop flag.
- mem_cen  out  1  SRAM chip enable, active-high.
- mem_wen  out  1  SRAM write enable, active-high.
- mem_addr  out  ADDR_WIDTH  SRAM address.
- mem_d  out  DATA_WIDTH  SRAM write data.
- mem_q  in  DATA_WIDTH  SRAM read data, valid one cycle after a read access.

Function
REQ-005 SHALL implement FSM states ST_INIT and ST_RUN; reset enters ST_INIT; ST_INIT goes to ST_RUN when initialisation completes (REQ-017/018).
REQ-006 SHALL drive rdy_data high only in ST_RUN, and SHALL ignore dram_en_rd/dram_en_wr while rdy_data is low.
REQ-007 SHALL return read data with fixed latency 2: a read sampled at edge N gives dram_valid=1 and data_in valid for exactly one cycle after edge N+2.
REQ-008 SHALL accept one read and one write in the same cycle; back-to-back requests every cycle SHALL be sustained.
REQ-009 SHALL buffer writes in a WB_DEPTH-entry FIFO of {addr, data}.
REQ-010 SHALL give the single SRAM port to a read when dram_en_rd is high; otherwise it SHALL drain the oldest buffer entry.
REQ-011 SHALL write straight to SRAM, bypassing the FIFO, when the FIFO is empty and no read is pending that cycle.
REQ-012 SHALL forward read data from the youngest FIFO entry whose addr equals addr_in at request time, overriding mem_q.
REQ-013 SHALL NOT forward a write sampled in the same cycle as a read to the same address; that read returns the prior value.
REQ-014 SHALL handle a write arriving on a full FIFO with a read in the same cycle by dropping the write and setting wb_ovf=1 until reset.
REQ-015 SHALL handle a write on a full FIFO with no read by draining the oldest entry and enqueuing the new one, so no drop occurs.
REQ-016 SHALL keep pointers modulo WB_DEPTH, with an explicit count for full/empty.

Reset
REQ-017 SHALL, while srstn=0, force data_in=0, dram_valid=0, rdy_data=0, wb_ovf=0, mem_cen=0, mem_wen=0, mem_addr=0, mem_d=0, FIFO empty and read pipeline cleared.
REQ-018 SHALL discard all in-flight reads and buffered writes when reset is asserted mid-operation, with no dram_valid pulse afterwards.

Configuration
REQ-019 SHALL, with DRAM_RESP_INIT_CLEAR_EN defined, sweep the SRAM in ST_INIT by writing 0 to addresses 0..2**ADDR_WIDTH-1 one per cycle, then enter ST_RUN.
REQ-020 SHALL, without DRAM_RESP_INIT_CLEAR_EN, enter ST_RUN on the first clock edge after reset release, leaving memory contents undefined.

Structure
REQ-021 SHALL take state encodings (ST_INIT, ST_RUN) and the read-latency constant from the shared package dram_pkg.
REQ-022 SHALL instantiate one sub-module, dram_wbuf, for the write FIFO, its full/count logic and the address-match forwarding lookup.

Verification
REQ-023 Bench SHALL cover:
- write 0x5 to addr 0x10, idle 10 cycles, read 0x10 -> data_in=0x5 with dram_valid 2 cycles after the request.
- write 0xA to 0x20 and read 0x20 at the same time, then read 0x20 the next cycle -> first read returns the old value, second returns 0xA (forwarded).
- 4 writes to 0x0..0x3 during continuous reads, then a 5th write plus a read -> write dropped, wb_ovf=1, and reading 0x4 later returns the old value.
- 100 cycles of alternating read/write, compared against a scoreboard model -> zero mismatches and one dram_valid per read.
- reset asserted with 2 reads in flight -> no dram_valid; after release rdy_data rises per the macro setting.
- with DRAM_RESP_INIT_CLEAR_EN and ADDR_WIDTH=4 -> rdy_data rises 16 cycles after reset release, and reading any address returns 0.
